// File: rtl/project2_switch_poller_if.sv
// Avalon-MM read bus between the switch poller and the switches PIO.
// Master drives address/read; slave returns waitrequest/readdata.
interface project2_switch_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/project2_switch_poller.sv
// Periodic Avalon-MM poller of the switches PIO with debounce and strobes.
// Define SW_POLLER_IRQ_EN to add a sticky irq output with irq_ack.
module project2_switch_poller #(
  parameter int DATA_W     = 4,
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     poll_now,
  project2_switch_poller_if.master avm,
  output logic [DATA_W-1:0]        sw_state,
  output logic                     sw_changed,
  output logic [DATA_W-1:0]        sw_rise,
  output logic [DATA_W-1:0]        sw_fall
`ifdef SW_POLLER_IRQ_EN
  ,
  output logic                     irq,
  input  logic                     irq_ack
`endif
);

  localparam int TW = $clog2(POLL_DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL
  } state_t;

  state_t            r_fsm;
  state_t            w_fsm_nx;
  logic [TW-1:0]     r_timer;
  logic              r_pending;
  logic [DATA_W-1:0] r_sample;
  logic [DATA_W-1:0] r_cand;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_state;
  logic              r_chg;
  logic [DATA_W-1:0] r_rise;
  logic [DATA_W-1:0] r_fall;

  logic              w_trig;
  logic              w_go;
  logic              w_leave;
  logic              w_read;
  logic [3:0]        w_cnt_nx;
  logic              w_commit;
  logic              w_unused_rd;

  assign w_trig = enable &&
    (r_timer == TW'(POLL_DIV - 1));
  assign w_go = r_pending | w_trig | poll_now;

  always_comb begin
    w_fsm_nx = r_fsm;
    w_read   = 1'b0;
    w_leave  = 1'b0;
    unique case (r_fsm)
      S_IDLE: begin
        if (w_go) begin
          w_fsm_nx = S_REQ;
          w_leave  = 1'b1;
        end
      end
      S_REQ: begin
        w_read = 1'b1;
        if (!avm.avm_waitrequest)
          w_fsm_nx = S_WAIT;
      end
      S_WAIT:  w_fsm_nx = S_EVAL;
      S_EVAL:  w_fsm_nx = S_IDLE;
      default: w_fsm_nx = S_IDLE;
    endcase
  end

  // candidate always follows the newest sample; only the run length varies
  always_comb begin
    w_cnt_nx = 4'd1;
    if (r_sample == r_cand)
      w_cnt_nx = (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
    w_commit = (r_fsm == S_EVAL) &&
      (w_cnt_nx >= 4'(DEBOUNCE_N)) &&
      (r_sample != r_state);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm     <= S_IDLE;
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_sample  <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_state   <= '0;
      r_chg     <= 1'b0;
      r_rise    <= '0;
      r_fall    <= '0;
    end else begin
      r_fsm <= w_fsm_nx;
      if (!enable || w_trig)
        r_timer <= '0;
      else
        r_timer <= r_timer + TW'(1);
      if (w_leave)
        r_pending <= 1'b0;
      else if (w_trig || poll_now)
        r_pending <= 1'b1;
      if (r_fsm == S_WAIT)
        r_sample <= avm.avm_readdata[DATA_W-1:0];
      if (r_fsm == S_EVAL) begin
        r_cand <= r_sample;
        r_cnt  <= w_cnt_nx;
      end
      r_chg  <= 1'b0;
      r_rise <= '0;
      r_fall <= '0;
      if (w_commit) begin
        r_state <= r_sample;
        r_rise  <= r_sample & ~r_state;
        r_fall  <= ~r_sample & r_state;
        r_chg   <= 1'b1;
      end
    end
  end

`ifdef SW_POLLER_IRQ_EN
  logic r_irq;

  // a new change outranks an acknowledge in the same cycle
  always_ff @(posedge clk) begin
    if (reset)
      r_irq <= 1'b0;
    else if (w_commit)
      r_irq <= 1'b1;
    else if (irq_ack)
      r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

  assign w_unused_rd     = ^avm.avm_readdata[31:DATA_W];
  assign avm.avm_address = 2'b00;
  assign avm.avm_read    = w_read;
  assign sw_state        = r_state;
  assign sw_changed      = r_chg;
  assign sw_rise         = r_rise;
  assign sw_fall         = r_fall;

endmodule
